// File: rtl/mcycle_ctrl_pkg.sv
// Package mcycle_pkg: shared encodings for the multi-cycle MIPS control unit.
//   state_t       : FSM state codes (IF=0 .. ERR=14), 5-bit
//   OP_* / FN_*   : opcode (inst[31:26]) and R-type funct (inst[5:0]) values
//   ALU_*         : ALU_Control codes
//   SRCB_*        : ALUSrc_B operand select encodings
//   DTR_*         : DatatoReg write-back source encodings
//   BR_*          : Branch (PC source) encodings
//   op_of/funct_of: instruction field helpers
package mcycle_pkg;

  typedef enum logic [4:0] {
    S_IF    = 5'd0,
    S_ID    = 5'd1,
    S_MADDR = 5'd2,
    S_MRD   = 5'd3,
    S_LWB   = 5'd4,
    S_MWR   = 5'd5,
    S_REXE  = 5'd6,
    S_RWB   = 5'd7,
    S_BR    = 5'd8,
    S_J     = 5'd9,
    S_IEXE  = 5'd10,
    S_IWB   = 5'd11,
    S_JAL   = 5'd12,
    S_JR    = 5'd13,
    S_ERR   = 5'd14
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type functs
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU_Control
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUSrc_B
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // DatatoReg
  localparam logic [1:0] DTR_ALU = 2'b00;
  localparam logic [1:0] DTR_MEM = 2'b01;
  localparam logic [1:0] DTR_LUI = 2'b10;
  localparam logic [1:0] DTR_PC  = 2'b11;

  // Branch (PC source)
  localparam logic [1:0] BR_ALU    = 2'b00;
  localparam logic [1:0] BR_TARGET = 2'b01;
  localparam logic [1:0] BR_JUMP   = 2'b10;
  localparam logic [1:0] BR_RS     = 2'b11;

  function automatic logic [5:0] op_of(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] inst);
    return inst[5:0];
  endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// Interface mcycle_ctrl_if: control-unit <-> datapath/memory bundle.
//   master : the control unit (consumes inst/flags/MIO_ready, drives controls)
//   slave  : the datapath/memory side (drives inst/flags/MIO_ready)
//
// Memory handshake: while the controller presents an access (CPU_MIO=1 with
// MemRead or MemWrite), the request and its qualifiers stay stable. The
// access completes on the first rising clk edge at which MIO_ready=1; the
// controller only then leaves the access state. MIO_ready outside an access
// is ignored. A reset abandons any access in flight.
interface mcycle_ctrl_if;
  logic [31:0] inst;
  logic        zero;
  logic        overflow;
  logic        MIO_ready;
  logic [2:0]  ALU_Control;
  logic        ALUSrc_A;
  logic [1:0]  ALUSrc_B;
  logic        RegDst;
  logic        Jal;
  logic        RegWrite;
  logic [1:0]  DatatoReg;
  logic [1:0]  Branch;
  logic        PCWrite;
  logic        IRWrite;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        CPU_MIO;
  logic        err;
  logic [4:0]  state;

  modport master (
    input  inst, zero, overflow, MIO_ready,
    output ALU_Control, ALUSrc_A, ALUSrc_B, RegDst, Jal, RegWrite,
           DatatoReg, Branch, PCWrite, IRWrite, IorD, MemRead, MemWrite,
           CPU_MIO, err, state
  );

  modport slave (
    output inst, zero, overflow, MIO_ready,
    input  ALU_Control, ALUSrc_A, ALUSrc_B, RegDst, Jal, RegWrite,
           DatatoReg, Branch, PCWrite, IRWrite, IorD, MemRead, MemWrite,
           CPU_MIO, err, state
  );
endinterface

// File: rtl/mcycle_ctrl_alu_ctrl_dec.sv
// alu_ctrl_dec: combinational R-type funct -> ALU_Control decode.
//   funct    : inst[5:0]
//   alu_ctrl : ALU operation for the R-type execute step
//   valid    : 1 when funct is one of the supported ALU functs
module alu_ctrl_dec
  import mcycle_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       valid
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_XOR:  alu_ctrl = ALU_XOR;
      FN_NOR:  alu_ctrl = ALU_NOR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      FN_SRL:  alu_ctrl = ALU_SRL;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: Moore control FSM for a multi-cycle MIPS subset datapath.
//   clk : rising-edge clock
//   rst : synchronous active-low reset; forces IF and abandons any access
//   bus : mcycle_ctrl_if.master -- inst/zero/overflow/MIO_ready in,
//         datapath/memory controls plus 5-bit state code out
// Outputs are decoded from the current state and inst. Besides the memory
// ready strobe feeding PCWrite in IF, only PCWrite in BR looks at zero.
module mcycle_ctrl
  import mcycle_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mcycle_ctrl_if.master bus
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op;
  logic [5:0] funct;
  logic [2:0] r_alu;
  logic       r_valid;
  logic       r_ovf_op;
  logic       unused_inst_bits;

  assign op               = op_of(bus.inst);
  assign funct            = funct_of(bus.inst);
  assign unused_inst_bits = ^bus.inst[25:6];

  // Only signed add/sub suppress write-back on overflow.
  assign r_ovf_op = (funct == FN_ADD) || (funct == FN_SUB);

  alu_ctrl_dec u_alu_ctrl_dec (
    .funct    (funct),
    .alu_ctrl (r_alu),
    .valid    (r_valid)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:    if (bus.MIO_ready) state_d = S_ID;
      S_ID: begin
        case (op)
          OP_RTYPE: begin
            if (funct == FN_JR)  state_d = S_JR;
            else if (r_valid)    state_d = S_REXE;
            else                 state_d = S_ERR;
          end
          OP_LW, OP_SW:              state_d = S_MADDR;
          OP_BEQ, OP_BNE:            state_d = S_BR;
          OP_J:                      state_d = S_J;
          OP_JAL:                    state_d = S_JAL;
          OP_ADDI, OP_SLTI, OP_LUI:  state_d = S_IEXE;
          default:                   state_d = S_ERR;
        endcase
      end
      S_MADDR: begin
        if (op == OP_LW)      state_d = S_MRD;
        else if (op == OP_SW) state_d = S_MWR;
        else                  state_d = S_ERR;
      end
      S_MRD:   if (bus.MIO_ready) state_d = S_LWB;
      S_MWR:   if (bus.MIO_ready) state_d = S_IF;
      S_REXE:  state_d = S_RWB;
      S_IEXE:  state_d = S_IWB;
      S_LWB, S_RWB, S_IWB, S_BR, S_J, S_JAL, S_JR: state_d = S_IF;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IF;
    else      state_q <= state_d;
  end

  // Output decode
  logic [2:0] alu_control;
  logic       alusrc_a;
  logic [1:0] alusrc_b;
  logic       reg_dst;
  logic       jal;
  logic       reg_write;
  logic [1:0] data_to_reg;
  logic [1:0] branch;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       cpu_mio;
  logic       err;

  always_comb begin
    alu_control = 3'b000;
    alusrc_a    = 1'b0;
    alusrc_b    = SRCB_RT;
    reg_dst     = 1'b0;
    jal         = 1'b0;
    reg_write   = 1'b0;
    data_to_reg = DTR_ALU;
    branch      = BR_ALU;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    cpu_mio     = 1'b0;
    err         = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read    = 1'b1;
        cpu_mio     = 1'b1;
        ir_write    = 1'b1;
        alusrc_b    = SRCB_FOUR;
        alu_control = ALU_ADD;
        // PC+4 commits with the fetch; held off while reset is asserted.
        pc_write    = bus.MIO_ready & rst;
      end
      S_ID: begin
        alusrc_b    = SRCB_IMM_SH;
        alu_control = ALU_ADD;
      end
      S_MADDR: begin
        alusrc_a    = 1'b1;
        alusrc_b    = SRCB_IMM;
        alu_control = ALU_ADD;
      end
      S_MRD: begin
        i_or_d   = 1'b1;
        cpu_mio  = 1'b1;
        mem_read = 1'b1;
      end
      S_MWR: begin
        i_or_d    = 1'b1;
        cpu_mio   = 1'b1;
        mem_write = 1'b1;
      end
      S_LWB: begin
        reg_write   = 1'b1;
        data_to_reg = DTR_MEM;
      end
      S_REXE: begin
        alusrc_a    = 1'b1;
        alusrc_b    = SRCB_RT;
        alu_control = r_alu;
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = ~(bus.overflow & r_ovf_op);
      end
      S_IEXE: begin
        alusrc_a    = 1'b1;
        alusrc_b    = SRCB_IMM;
        // lui ignores the ALU result, so add is as good as anything there.
        alu_control = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IWB: begin
        data_to_reg = (op == OP_LUI) ? DTR_LUI : DTR_ALU;
        reg_write   = ~(bus.overflow & (op == OP_ADDI));
      end
      S_BR: begin
        alusrc_a    = 1'b1;
        alusrc_b    = SRCB_RT;
        alu_control = ALU_SUB;
        branch      = BR_TARGET;
        pc_write    = (op == OP_BEQ) ? bus.zero : ~bus.zero;
      end
      S_J: begin
        branch   = BR_JUMP;
        pc_write = 1'b1;
      end
      S_JAL: begin
        branch      = BR_JUMP;
        pc_write    = 1'b1;
        reg_write   = 1'b1;
        jal         = 1'b1;
        data_to_reg = DTR_PC;
      end
      S_JR: begin
        branch   = BR_RS;
        pc_write = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  assign bus.ALU_Control = alu_control;
  assign bus.ALUSrc_A    = alusrc_a;
  assign bus.ALUSrc_B    = alusrc_b;
  assign bus.RegDst      = reg_dst;
  assign bus.Jal         = jal;
  assign bus.RegWrite    = reg_write;
  assign bus.DatatoReg   = data_to_reg;
  assign bus.Branch      = branch;
  assign bus.PCWrite     = pc_write;
  assign bus.IRWrite     = ir_write;
  assign bus.IorD        = i_or_d;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.CPU_MIO     = cpu_mio;
  assign bus.err         = err;
  assign bus.state       = state_q;

endmodule
